branch_predictor: RTL

- Dynamic branch predictor and redirect controller for the 5-stage RISC-V pipeline.
- Fetch side: direct-mapped BTB of 2-bit saturating counters gives a predicted next PC each cycle.
- Execute side: compares the Branch Unit's resolved outcome with the prediction carried down the pipe, then raises Mispredict and Redirect_PC to flush IF/ID.
- Table update happens on the clock edge after resolution.

---
 rtl/branch_predictor.sv | 121 ++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, plus execute-stage
// mispredict detection, redirect generation and branch statistics.
module branch_predictor #(
    parameter int PC_W  = 9,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   If_PC,
    output logic              Pred_Taken,
    output logic [31:0]       Pred_PC,
    input  logic              Ex_Valid,
    input  logic [PC_W-1:0]   Ex_PC,
    input  logic              Ex_Branch,
    input  logic              Ex_Jump,
    input  logic              Ex_Jalr,
    input  logic              Ex_Taken,
    input  logic [31:0]       Ex_Target,
    input  logic              Ex_Pred_Taken,
    input  logic [31:0]       Ex_Pred_PC,
    input  logic              Halt,
    output logic              Mispredict,
    output logic [31:0]       Redirect_PC,
    output logic [CNT_W-1:0]  Branch_Count,
    output logic [CNT_W-1:0]  Mispred_Count
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = PC_W - IDX_W - 2;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [PC_W-1:0]   target_q [ENTRIES];
    logic [1:0]        cnt_q    [ENTRIES];
    logic [CNT_W-1:0]  branch_count_q;
    logic [CNT_W-1:0]  mispred_count_q;

    logic [IDX_W-1:0]  if_idx;
    logic [TAG_W-1:0]  if_tag;
    logic              if_hit;
    logic [IDX_W-1:0]  ex_idx;
    logic [TAG_W-1:0]  ex_tag;
    logic              ex_hit;
    logic              ctl;
    logic              is_jump;

    logic              upd_en;
    logic [1:0]        new_cnt;
    logic [PC_W-1:0]   new_target;

    assign if_idx = If_PC[IDX_W+1:2];
    assign if_tag = If_PC[PC_W-1:IDX_W+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    // Lookup reads the pre-update table; a same-cycle write is visible next cycle.
    assign Pred_Taken = if_hit && cnt_q[if_idx][1] && !Halt;
    assign Pred_PC    = Pred_Taken ? {{(32-PC_W){1'b0}}, target_q[if_idx]} : 32'd0;

    assign ex_idx  = Ex_PC[IDX_W+1:2];
    assign ex_tag  = Ex_PC[PC_W-1:IDX_W+2];
    assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign is_jump = Ex_Jump || Ex_Jalr;
    assign ctl     = Ex_Valid && (Ex_Branch || is_jump) && !Halt;

    assign Mispredict  = ctl && ((Ex_Taken != Ex_Pred_Taken) ||
                                 (Ex_Taken && (Ex_Target != Ex_Pred_PC)));
    assign Redirect_PC = Ex_Taken ? Ex_Target
                                  : ({{(32-PC_W){1'b0}}, Ex_PC} + 32'd4);

    assign Branch_Count  = branch_count_q;
    assign Mispred_Count = mispred_count_q;

    // Next contents of the EX entry; jumps take priority over the branch flag.
    always_comb begin
        upd_en     = 1'b0;
        new_cnt    = cnt_q[ex_idx];
        new_target = target_q[ex_idx];
        if (ctl) begin
            if (ex_hit) begin
                upd_en = 1'b1;
                if (is_jump) begin
                    new_cnt    = 2'b11;
                    new_target = Ex_Target[PC_W-1:0];
                end else if (Ex_Taken) begin
                    new_cnt    = (cnt_q[ex_idx] == 2'b11) ? 2'b11 : cnt_q[ex_idx] + 2'd1;
                    new_target = Ex_Target[PC_W-1:0];
                end else begin
                    new_cnt = (cnt_q[ex_idx] == 2'b00) ? 2'b00 : cnt_q[ex_idx] - 2'd1;
                end
            end else if (Ex_Taken) begin
                upd_en     = 1'b1;
                new_cnt    = is_jump ? 2'b11 : 2'b10;
                new_target = Ex_Target[PC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'b01;
            end
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            if (upd_en) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= new_target;
                cnt_q[ex_idx]    <= new_cnt;
            end
            if (ctl && (branch_count_q != '1))
                branch_count_q <= branch_count_q + 1'b1;
            if (Mispredict && (mispred_count_q != '1))
                mispred_count_q <= mispred_count_q + 1'b1;
        end
    end

endmodule
